// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage
//  Purpose  : Memory-access pipeline stage between execute and write-back.
//             Owns a word-organised data memory with byte-lane write enables,
//             performs B/H/W(/D) loads and stores with lane selection from
//             the low address bits, sign/zero extension and misalignment
//             detection. An optional wait-state counter models slow memory
//             and back-pressures execute through in_valid/in_ready.
//  Ports    : clk, rst_n (async, active-low)
//             in_valid/in_ready      - execute handshake
//             alu_result, store_data - address / pass-through, store value
//             mem_read, mem_write    - op kind (write wins if both set)
//             size, unsigned_ld, rd  - access size, extension, dest tag
//             out_valid              - one-cycle strobe to write-back
//             alu_out, load_data, rd_out, misalign - registered results
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [1:0]      size,
    input  logic            unsigned_ld,
    input  logic [4:0]      rd,
    output logic            out_valid,
    output logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] load_data,
    output logic [4:0]      rd_out,
    output logic            misalign
);

    localparam int         LANES   = XLEN / 8;
    localparam int         OW      = $clog2(LANES);
    localparam int         AW      = $clog2(DEPTH_WORDS);
    localparam int         SW      = $clog2(XLEN);
    localparam logic [3:0] C_WAIT  = 4'(WAIT_STATES);
    localparam logic [3:0] C_LANES = 4'(LANES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            state_q;
    logic [3:0]        cnt_q;

    // Operation captured at accept; drives the datapath while in WAIT
    logic [XLEN-1:0]   pend_addr_q;
    logic [XLEN-1:0]   pend_wdata_q;
    logic [1:0]        pend_size_q;
    logic              pend_uns_q;
    logic              pend_ld_q;
    logic              pend_st_q;
    logic [4:0]        pend_rd_q;

    logic              out_valid_q;
    logic [XLEN-1:0]   alu_out_q;
    logic [XLEN-1:0]   load_data_q;
    logic [4:0]        rd_out_q;
    logic              misalign_q;

    // Data memory is intentionally not reset
    logic [XLEN-1:0]   mem_q [DEPTH_WORDS];

    // ------------------------------------------------------------------------
    // Datapath: operand source is the live input in IDLE, the latched op in
    // WAIT, so one lane/extension datapath serves both paths.
    // ------------------------------------------------------------------------
    logic              w_in_wait;
    logic [OW-1:0]     w_off;
    logic [AW-1:0]     w_idx;
    logic [1:0]        w_size;
    logic              w_uns;
    logic [XLEN-1:0]   w_wdata;
    logic              w_ld;
    logic              w_st;
    logic              w_memop;
    logic [3:0]        w_bytes;
    logic [7:0]        w_bits;
    logic              w_fault;
    logic              w_commit;
    logic              w_mem_we;
    logic [XLEN-1:0]   w_word;
    logic [XLEN-1:0]   w_shift;
    logic [XLEN-1:0]   w_mask;
    logic [SW-1:0]     w_msb;
    logic              w_fill;
    logic [XLEN-1:0]   w_ld_val;
    logic [LANES-1:0]  w_be_base;
    logic [LANES-1:0]  w_be;
    logic [XLEN-1:0]   w_wdata_sh;

    assign w_in_wait = (state_q == S_WAIT);
    assign w_off     = w_in_wait ? pend_addr_q[OW-1:0]    : alu_result[OW-1:0];
    assign w_idx     = w_in_wait ? pend_addr_q[AW+OW-1:OW] : alu_result[AW+OW-1:OW];
    assign w_size    = w_in_wait ? pend_size_q  : size;
    assign w_uns     = w_in_wait ? pend_uns_q   : unsigned_ld;
    assign w_wdata   = w_in_wait ? pend_wdata_q : store_data;
    // A store wins when both read and write are requested
    assign w_ld      = w_in_wait ? pend_ld_q    : (mem_read & ~mem_write);
    assign w_st      = w_in_wait ? pend_st_q    : mem_write;
    assign w_memop   = w_ld | w_st;

    assign w_bytes   = 4'd1 << w_size;
    assign w_bits    = 8'd8 << w_size;

    // Only memory ops can fault; pass-through values are never flagged
    assign w_fault   = w_memop & ((w_bytes > C_LANES) |
                                  ((4'(w_off) & (w_bytes - 4'd1)) != 4'd0));

    // Memory access happens at the accept edge (no wait states) or at the
    // edge where the wait counter reaches 1. Gated by rst_n so a request
    // seen while reset is asserted can never write the array.
    assign w_commit  = rst_n & w_memop & ~w_fault &
                       (w_in_wait ? (cnt_q == 4'd1)
                                  : (in_valid && (WAIT_STATES == 0)));
    assign w_mem_we  = w_commit & w_st;

    // Load path: shift the selected lane to bit 0, keep 8*2^size bits, extend
    assign w_word    = mem_q[w_idx];
    assign w_shift   = w_word >> {w_off, 3'b000};
    assign w_mask    = ~({XLEN{1'b1}} << w_bits);
    assign w_msb     = SW'(w_bits - 8'd1);
    assign w_fill    = ~w_uns & w_shift[w_msb];
    assign w_ld_val  = (w_shift & w_mask) | ({XLEN{w_fill}} & ~w_mask);

    // Store path: 2^size contiguous lanes starting at the offset lane
    assign w_be_base  = (LANES'(1) << w_bytes) - LANES'(1);
    assign w_be       = w_be_base << w_off;
    assign w_wdata_sh = w_wdata << {w_off, 3'b000};

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int l = 0; l < LANES; l++) begin
                if (w_be[l]) begin
                    mem_q[w_idx][8*l +: 8] <= w_wdata_sh[8*l +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            pend_size_q  <= 2'd0;
            pend_uns_q   <= 1'b0;
            pend_ld_q    <= 1'b0;
            pend_st_q    <= 1'b0;
            pend_rd_q    <= 5'd0;
            out_valid_q  <= 1'b0;
            alu_out_q    <= '0;
            load_data_q  <= '0;
            rd_out_q     <= 5'd0;
            misalign_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        pend_addr_q  <= alu_result;
                        pend_wdata_q <= store_data;
                        pend_size_q  <= size;
                        pend_uns_q   <= unsigned_ld;
                        pend_ld_q    <= mem_read & ~mem_write;
                        pend_st_q    <= mem_write;
                        pend_rd_q    <= rd;
                        if (w_memop && !w_fault && (WAIT_STATES != 0)) begin
                            cnt_q   <= C_WAIT;
                            state_q <= S_WAIT;
                        end else begin
                            // Pass-through, faulting, or zero-wait memory op
                            out_valid_q <= 1'b1;
                            alu_out_q   <= alu_result;
                            rd_out_q    <= rd;
                            misalign_q  <= w_fault;
                            load_data_q <= (w_ld && !w_fault) ? w_ld_val : '0;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b1;
                        alu_out_q   <= pend_addr_q;
                        rd_out_q    <= pend_rd_q;
                        misalign_q  <= 1'b0;
                        load_data_q <= pend_ld_q ? w_ld_val : '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign alu_out   = alu_out_q;
    assign load_data = load_data_q;
    assign rd_out    = rd_out_q;
    assign misalign  = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_stage
//  Purpose  : Scoreboard bench for mem_access_stage. Three instances:
//             u0 XLEN=32 W=0, u1 XLEN=32 W=3, u2 XLEN=64 DEPTH=64 W=0.
//             A byte-addressed reference memory predicts each result, which
//             is queued with its expected arrival cycle; a monitor pops and
//             compares whenever an instance strobes out_valid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] a_i   = '0;
    logic [63:0] wd_i  = '0;
    logic        rd_op = 1'b0;
    logic        wr_op = 1'b0;
    logic        uns_i = 1'b0;
    logic [1:0]  sz_i  = 2'd0;
    logic [4:0]  rd_i  = 5'd0;
    logic        iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0;
    logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, mis0, mis1, mis2;
    logic [31:0] ao0, ao1, ld0, ld1;
    logic [63:0] ao2, ld2;
    logic [4:0]  ro0, ro1, ro2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [63:0] alu;
        logic [63:0] ld;
        logic [4:0]  rd;
        logic        mis;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic [7:0] mm [3][4096];

    mem_access_stage #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(rdy0),
        .alu_result(a_i[31:0]), .store_data(wd_i[31:0]), .mem_read(rd_op),
        .mem_write(wr_op), .size(sz_i), .unsigned_ld(uns_i), .rd(rd_i),
        .out_valid(ov0), .alu_out(ao0), .load_data(ld0), .rd_out(ro0),
        .misalign(mis0));

    mem_access_stage #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(3)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1),
        .alu_result(a_i[31:0]), .store_data(wd_i[31:0]), .mem_read(rd_op),
        .mem_write(wr_op), .size(sz_i), .unsigned_ld(uns_i), .rd(rd_i),
        .out_valid(ov1), .alu_out(ao1), .load_data(ld1), .rd_out(ro1),
        .misalign(mis1));

    mem_access_stage #(.XLEN(64), .DEPTH_WORDS(64), .WAIT_STATES(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(rdy2),
        .alu_result(a_i), .store_data(wd_i), .mem_read(rd_op),
        .mem_write(wr_op), .size(sz_i), .unsigned_ld(uns_i), .rd(rd_i),
        .out_valid(ov2), .alu_out(ao2), .load_data(ld2), .rd_out(ro2),
        .misalign(mis2));

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic observe(input int d, output logic v, output logic [63:0] a,
                           output logic [63:0] l, output logic [4:0] r,
                           output logic m, output logic rdy);
        case (d)
            0: begin v = ov0; a = {32'd0, ao0}; l = {32'd0, ld0}; r = ro0; m = mis0; rdy = rdy0; end
            1: begin v = ov1; a = {32'd0, ao1}; l = {32'd0, ld1}; r = ro1; m = mis1; rdy = rdy1; end
            default: begin v = ov2; a = ao2; l = ld2; r = ro2; m = mis2; rdy = rdy2; end
        endcase
    endtask

    task automatic set_iv(input int d, input logic v);
        case (d)
            0: iv0 = v;
            1: iv1 = v;
            default: iv2 = v;
        endcase
    endtask

    // Reference model: byte-addressed memory; word index wraps, so the byte
    // address simply wraps modulo the memory size in bytes.
    function automatic exp_t predict(input int d, input logic [63:0] a,
                                     input logic [63:0] wd, input logic [4:0] r,
                                     input logic rdop, input logic wrop,
                                     input logic [1:0] sz, input logic uns,
                                     output int lat);
        int          lanes = (d == 2) ? 8 : 4;
        int          memb  = (d == 2) ? 512 : 4096;
        int          nb    = 1 << sz;
        int          off;
        int          base;
        logic [63:0] v;
        logic [63:0] xm    = (d == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        exp_t        e;
        e.alu = a & xm;
        e.rd  = r;
        e.ld  = '0;
        e.mis = 1'b0;
        e.cyc = 0;
        lat   = 0;
        if (rdop || wrop) begin
            off = int'(a[2:0]) % lanes;
            if (nb > lanes || (off % nb) != 0) begin
                e.mis = 1'b1;
            end else begin
                base = int'(a[15:0]) % memb;
                lat  = (d == 1) ? 3 : 0;
                if (wrop) begin
                    for (int i = 0; i < nb; i++) mm[d][base+i] = wd[8*i +: 8];
                end else begin
                    v = '0;
                    for (int i = 0; i < nb; i++) v[8*i +: 8] = mm[d][base+i];
                    if (!uns && nb < 8 && v[8*nb-1]) v = v | (~64'd0 << (8*nb));
                    e.ld = v & xm;
                end
            end
        end
        return e;
    endfunction

    task automatic push_exp(input int d, input exp_t e);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int d, output bit ok, output exp_t e);
        ok = 1'b0;
        case (d)
            0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    function automatic int qsize(input int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input int d, input logic [63:0] a, input logic [63:0] wd,
                         input logic [4:0] r, input logic rdop, input logic wrop,
                         input logic [1:0] sz, input logic uns, input bit push);
        bit          got = 1'b0;
        int          waited = 0;
        int          lat;
        exp_t        e;
        logic        v, m, rdy;
        logic [63:0] oa, ol;
        logic [4:0]  orr;
        a_i = a; wd_i = wd; rd_i = r; rd_op = rdop; wr_op = wrop; sz_i = sz; uns_i = uns;
        set_iv(d, 1'b1);
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            observe(d, v, oa, ol, orr, m, rdy);
            if (rdy) begin
                got = 1'b1;
                break;
            end
            waited++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut=%0d actual=not_ready required=ready", d);
        end else begin
            if (d != 1) chk($sformatf("d%0d_in_ready_stall", d), 64'(waited), 64'd0);
            if (push) begin
                e     = predict(d, a, wd, r, rdop, wrop, sz, uns, lat);
                e.cyc = cyc + 1 + lat;
                push_exp(d, e);
            end
        end
        @(posedge clk);
        #1;
        set_iv(d, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    initial forever begin
        logic        v, m, rdy;
        logic [63:0] oa, ol;
        logic [4:0]  orr;
        exp_t        e;
        bit          ok;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            observe(d, v, oa, ol, orr, m, rdy);
            if (v === 1'b1) begin
                pop_exp(d, ok, e);
                if (!ok) begin
                    checks++;
                    errors++;
                    $display("FAIL d%0d_unexpected_out_valid actual=1 required=0 alu_out=%h", d, oa);
                end else begin
                    chk($sformatf("d%0d_latency_cycle", d), 64'(cyc), 64'(e.cyc));
                    chk($sformatf("d%0d_alu_out", d), oa, e.alu);
                    chk($sformatf("d%0d_load_data", d), ol, e.ld);
                    chk($sformatf("d%0d_rd_out", d), 64'(orr), 64'(e.rd));
                    chk($sformatf("d%0d_misalign", d), 64'(m), 64'(e.mis));
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic        v, m, rdy;
        logic [63:0] oa, ol;
        logic [4:0]  orr;
        logic [63:0] ra, rwd;
        int          kind;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            observe(d, v, oa, ol, orr, m, rdy);
            chk($sformatf("d%0d_reset_ctrl", d), 64'({rdy, v, m, orr}), 64'h80);
            chk($sformatf("d%0d_reset_alu_out", d), oa, 64'd0);
            chk($sformatf("d%0d_reset_load_data", d), ol, 64'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // ---- u0: XLEN=32, no wait states ----
        issue(0, 64'h10, 64'hDEADBEEF, 5'd1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1); // SW
        issue(0, 64'h10, 64'h0,        5'd2, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1); // LW
        issue(0, 64'h13, 64'h0,        5'd3, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1); // LB
        issue(0, 64'h13, 64'h0,        5'd4, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1); // LBU
        issue(0, 64'h12, 64'h0,        5'd5, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1); // LH
        issue(0, 64'h11, 64'h55,       5'd6, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1); // SB
        issue(0, 64'h10, 64'h0,        5'd7, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1); // LW
        issue(0, 64'h11, 64'h0,        5'd8, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1); // LH misaligned
        issue(0, 64'h12, 64'hFFFF,     5'd9, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1); // SW misaligned
        issue(0, 64'h10, 64'h0,        5'd10, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1); // LD on 32-bit
        issue(0, 64'h10, 64'h0,        5'd11, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1); // LW unchanged
        issue(0, 64'h12345673, 64'h0,  5'd12, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1); // pass-through
        issue(0, 64'h14, 64'h11223344, 5'd13, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1); // R+W -> store
        issue(0, 64'h14, 64'h0,        5'd14, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
        idle(2);

        // ---- u1: XLEN=32, three wait states ----
        issue(1, 64'h20, 64'hCAFEF00D, 5'd1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
        issue(1, 64'h20, 64'h0,        5'd2, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
        fork
            issue(1, 64'h5555, 64'h0, 5'd9, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
            begin
                for (int k = 1; k <= 3; k++) begin
                    @(negedge clk);
                    chk($sformatf("d1_in_ready_wait_cycle%0d", k), 64'(rdy1), 64'd0);
                end
                @(negedge clk);
                chk("d1_in_ready_after_wait", 64'(rdy1), 64'd1);
            end
        join
        idle(3);
        // Store dropped by reset in the middle of its wait
        issue(1, 64'h20, 64'h12345678, 5'd4, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("d1_in_ready_in_reset", 64'(rdy1), 64'd1);
        chk("d1_out_valid_in_reset", 64'(ov1), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);
        issue(1, 64'h20, 64'h0, 5'd5, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
        idle(4);

        // ---- u2: XLEN=64, DEPTH_WORDS=64 ----
        issue(2, 64'h8,   64'h0123456789ABCDEF, 5'd1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1); // SD
        issue(2, 64'hC,   64'h0, 5'd2, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1); // LW
        issue(2, 64'h20C, 64'h0, 5'd3, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1); // alias
        issue(2, 64'h208, 64'h0, 5'd4, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1); // LD alias
        issue(2, 64'h8,   64'h0, 5'd5, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1); // LB
        issue(2, 64'h4,   64'h0, 5'd6, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1); // LD misaligned
        issue(2, 64'h8,   64'h0, 5'd7, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1); // LW low half
        idle(2);

        // ---- randomized traffic on every instance ----
        for (int d = 0; d < 3; d++) begin
            for (int w = 0; w < 16; w++) begin
                issue(d, 64'(32'h40 + 4*w), 64'($urandom), 5'(w), 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
            end
            for (int n = 0; n < 120; n++) begin
                kind = int'($urandom % 8);
                ra   = {32'($urandom), (32'($urandom) & 32'hFFFF_0000) | (32'h40 + 32'($urandom % 64))};
                rwd  = {32'($urandom), 32'($urandom)};
                if (kind == 0) begin
                    issue(d, rwd, 64'h0, 5'($urandom), 1'b0, 1'b0, 2'($urandom), 1'($urandom), 1'b1);
                end else if (kind < 4) begin
                    issue(d, ra, rwd, 5'($urandom), 1'($urandom), 1'b1, 2'($urandom), 1'($urandom), 1'b1);
                end else begin
                    issue(d, ra, rwd, 5'($urandom), 1'b1, 1'b0, 2'($urandom), 1'($urandom), 1'b1);
                end
                if (($urandom % 4) == 0) idle(1);
            end
            idle(6);
        end

        idle(10);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d_outstanding_results", d), 64'(qsize(d)), 64'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised memory-access pipeline stage for the pipelined RISC-V core, sitting between execute and write-back. It owns a word-organised data memory with byte-lane write enables and performs byte/half/word (and doubleword when XLEN=64) loads and stores. Lane selection comes from the low address bits, with sign/zero extension and misalignment detection. A configurable wait-state counter models slow memory and back-pressures execute through a valid/ready handshake.

## Interface
Parameters:
- XLEN, 32, data/address width; 32 or 64; LANES = XLEN/8 byte lanes
- DEPTH_WORDS, 1024, memory depth in XLEN-bit words (power of two)
- WAIT_STATES, 0, extra cycles per memory access (0..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute presents an operation
- in_ready  out  1  stage can accept; transfer when in_valid & in_ready
- alu_result  in  XLEN  byte address for memory ops, pass-through value otherwise
- store_data  in  XLEN  store value, right-aligned
- mem_read  in  1  load operation
- mem_write  in  1  store operation; wins if both set
- size  in  2  access size 2^size bytes (00 B, 01 H, 10 W, 11 D)
- unsigned_ld  in  1  zero-extend load (else sign-extend)
- rd  in  5  destination tag, passed through
- out_valid  out  1  one-cycle result strobe to write-back
- alu_out  out  XLEN  registered alu_result
- load_data  out  XLEN  extended load result; 0 for non-loads and faults
- rd_out  out  5  registered rd
- misalign  out  1  fault flag, qualified by out_valid

## Operation
- Clock is clk; reset is rst_n, asynchronous and active-low.
- FSM states: IDLE, WAIT. in_ready = (state == IDLE).
- Word index = alu_result[log2(DEPTH_WORDS)+log2(LANES)-1 : log2(LANES)]; higher bits ignored (address wraps). Offset = alu_result[log2(LANES)-1:0].
- Fault: misalign=1 if offset mod 2^size != 0, or 2^size > LANES. Faulting ops never touch memory and complete in one cycle.
- Store: byte enables set for lanes offset .. offset+2^size-1. Low 8·2^size bits of store_data are placed at lane offset. Other lanes are unchanged.
- Load: word shifted right by offset·8, low 8·2^size bits kept, then extended per unsigned_ld.
- Non-memory op (neither read nor write) and faulting op: registered and emitted with out_valid the next cycle; FSM stays IDLE.
- Memory op with WAIT_STATES=0: memory accessed at the accept edge; result is out the next cycle; back-to-back accepts allowed.
- Memory op with WAIT_STATES=W>0: accept edge latches the op, loads counter=W, and moves to WAIT. Counter decrements each edge. At the edge where the counter is 1, the memory access commits and the FSM returns to IDLE. out_valid is high in the following cycle.
- Memory contents are not cleared by reset.

## Timing
- Reset values: in_ready=1, out_valid=0, alu_out=0, load_data=0, rd_out=0, misalign=0, state=IDLE, counter=0.
- Latency from accept edge to out_valid cycle: 1 cycle for non-memory and faulting ops; 1+W cycles for memory ops.
- Throughput: one memory op per W+1 cycles.
- in_ready returns high in the same cycle out_valid is asserted.
- out_valid lasts exactly one cycle per accepted op; write-back never stalls.
- Inputs are ignored while in WAIT.
- Reset mid-WAIT: the pending store is dropped (memory unchanged), no out_valid is produced, and the FSM goes to IDLE.
- mem_read and mem_write both set: treated as a store; load_data=0.

## Test plan
- XLEN=32, W=0: store word 0xDEADBEEF at 0x10, then load word from 0x10 on the next cycle -> out_valid one cycle after each accept, load_data=0xDEADBEEF, in_ready stays 1.
- Byte/half extension: after the above, LB at 0x13 -> 0xFFFFFFDE; LBU at 0x13 -> 0x000000DE; LH at 0x12 -> 0xFFFFDEAD; SB 0x55 at 0x11 then LW 0x10 -> 0xDEAD55EF.
- Misalignment: LH at 0x11 and LW at 0x12 -> misalign=1, load_data=0, memory unchanged, one-cycle latency.
- W=3: LW accepted at cycle 0 -> in_ready low in cycles 1-3, out_valid in cycle 4; in_valid held high in cycles 1-3 is not accepted.
- Reset mid-operation, W=3: SW 0x12345678 to 0x20, rst_n low in cycle 2 -> no out_valid, in_ready=1 after reset, later LW 0x20 returns the old contents.
- XLEN=64, DEPTH_WORDS=64: SD 0x0123456789ABCDEF at 0x8, then LW at 0xC -> 0x0000000001234567; address 0x208 aliases 0x8.
